// File: rtl/wave_capture_ctrl_if.sv
// wave_capture_ctrl_if: codec-side inputs and capture/display-side outputs of wave_capture_ctrl.
//   master: drives the codec samples, view controls and display/capture status.
//   slave : the controller. It receives those and drives cap_*, armed, frozen and frame_count.
interface wave_capture_ctrl_if;
    logic        new_sample_ready;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic [1:0]  channel_sel;
    logic [1:0]  decim;
    logic [1:0]  mode;
    logic        arm;
    logic        wave_display_idle;
    logic        capture_read_index;
    logic        cap_sample_ready;
    logic [15:0] cap_sample;
    logic        cap_display_idle;
    logic        armed;
    logic        frozen;
    logic [7:0]  frame_count;
    modport master (
        output new_sample_ready, left_sample, right_sample, channel_sel, decim, mode, arm,
               wave_display_idle, capture_read_index,
        input  cap_sample_ready, cap_sample, cap_display_idle, armed, frozen, frame_count
    );
    modport slave (
        input  new_sample_ready, left_sample, right_sample, channel_sel, decim, mode, arm,
               wave_display_idle, capture_read_index,
        output cap_sample_ready, cap_sample, cap_display_idle, armed, frozen, frame_count
    );
endinterface

// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl: channel select/mix, block-average decimation, view FSM gating display idle, swap counter.
//   clk, reset : clock, synchronous active-high reset
//   bus (slave): sample stream in, cap_sample/cap_sample_ready out, idle gating, armed/frozen, frame_count
module wave_capture_ctrl (
    input logic           clk,
    input logic           reset,
    wave_capture_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, HOLD, SS_IDLE, SS_ARMED} state_t;
    state_t             state_q, state_d;
    logic [1:0]         mode_q, decim_q, dec_eff;
    logic               prev_idx_q, swap, done, ready_q, armed_q, frozen_q;
    logic [7:0]         frame_q;
    logic [2:0]         cnt_q;
    logic [15:0]        sel, cap_q;
    logic signed [18:0] acc_q, sum;
    always_comb begin
        sel = bus.channel_sel[1]
            ? 16'(($signed({bus.left_sample[15], bus.left_sample}) + $signed({bus.right_sample[15], bus.right_sample})) >>> 1)
            : bus.channel_sel[0] ? bus.right_sample : bus.left_sample;
        // the first sample of a block uses the live decim, which is latched for the rest of it
        dec_eff = (cnt_q == 3'd0) ? bus.decim : decim_q;
        done    = ({1'b0, cnt_q} + 4'd1) == (4'd1 << dec_eff);
        sum     = acc_q + $signed({{3{sel[15]}}, sel});
        swap    = bus.capture_read_index ^ prev_idx_q;
        state_d = (bus.mode != mode_q) ? (bus.mode[1] ? HOLD : bus.mode[0] ? SS_IDLE : RUN)
                : (state_q == SS_IDLE && bus.arm) ? SS_ARMED
                : (state_q == SS_ARMED && swap) ? SS_IDLE
                : state_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            mode_q     <= '0;
            decim_q    <= '0;
            prev_idx_q <= 1'b0;
            frame_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            cap_q      <= '0;
            ready_q    <= 1'b0;
            armed_q    <= 1'b0;
            frozen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= state_d == SS_ARMED;
            frozen_q   <= state_d == HOLD || state_d == SS_IDLE;
            mode_q     <= bus.mode;
            prev_idx_q <= bus.capture_read_index;
            frame_q    <= frame_q + {7'd0, swap};
            ready_q    <= bus.new_sample_ready && done;
            if (bus.new_sample_ready) begin
                if (cnt_q == 3'd0)
                    decim_q <= bus.decim;
                if (done) begin
                    cap_q <= 16'(sum >>> dec_eff);
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= sum;
                    cnt_q <= cnt_q + 3'd1;
                end
            end
        end
    end
    assign bus.cap_sample_ready = ready_q;
    assign bus.cap_sample       = cap_q;
    // combinational from the registered state so the capture block sees the gate in the same cycle
    assign bus.cap_display_idle = bus.wave_display_idle & (state_q == RUN || state_q == SS_ARMED);
    assign bus.armed            = armed_q;
    assign bus.frozen           = frozen_q;
    assign bus.frame_count      = frame_q;
endmodule
